imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 161 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational decode of the offered word feeding a
// 2-entry result FIFO (head/tail registers) with a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       illegal_cnt
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned ICNT_W  = 8;
  localparam bit          IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [6:0]       w_opcode;
  fmt_e             w_fmt;
  logic [31:0]      w_imm32;
  res_t             w_dec;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  res_t              r_head;
  res_t              r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [ICNT_W-1:0] r_illegal_cnt;

  assign w_opcode = in_instr[6:0];

  // Immediate decode; every 32-bit immediate is sign-extended from instr[31].
  always_comb begin
    w_fmt   = FMT_ILL;
    w_imm32 = 32'd0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_IMM32: begin
        if (IS_RV64) begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OP_STORE: begin
        w_fmt   = FMT_S;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        w_fmt   = FMT_B;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt   = FMT_U;
        w_imm32 = {in_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_REG: w_fmt = FMT_R;
      OP_REG32: begin
        if (IS_RV64) w_fmt = FMT_R;
      end
      default: w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.imm     = XLEN'($signed(w_imm32));
    w_dec.fmt     = w_fmt;
    w_dec.illegal = (w_fmt == FMT_ILL);
    w_dec.tag     = in_tag;
  end

  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = r_out_valid && out_ready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Head register drives out_*; tail only holds the second entry when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < CNT_W'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
      if (w_push && ((r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop))) begin
        r_head <= w_dec;
      end else if (w_pop && (r_count == CNT_W'(2))) begin
        r_head <= r_tail;
      end
      if (w_push && (r_count == CNT_W'(1)) && !w_pop) begin
        r_tail <= w_dec;
      end
      if (w_push && w_dec.illegal && (r_illegal_cnt != {ICNT_W{1'b1}})) begin
        r_illegal_cnt <= r_illegal_cnt + ICNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_head.imm;
  assign out_fmt     = r_head.fmt;
  assign out_illegal = r_head.illegal;
  assign out_tag     = r_head.tag;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32, TAG_W=5).
module tb_imm_gen_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [7:0]       illegal_cnt;

  int tests;
  int fails;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_tag     (out_tag),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_tag = '0; out_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b rdy=%0b imm=%h fmt=%0d ill=%0b tag=%0d cnt=%0d, want all 0",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%0b v=%0b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_i_format();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 ||
        out_illegal !== 1'b0 || out_tag !== 5'd3) begin
      fails++;
      $display("FAIL i_format: got v=%0b imm=%h fmt=%0d ill=%0b tag=%0d, want 1 ffffffff 1 0 3",
               out_valid, out_imm, out_fmt, out_illegal, out_tag);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL i_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_s_b();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_tag = 5'd4;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_fmt !== 3'd2 || out_tag !== 5'd4) begin
      fails++;
      $display("FAIL s_format: got v=%0b imm=%h fmt=%0d tag=%0d, want 1 fffffffc 2 4",
               out_valid, out_imm, out_fmt, out_tag);
    end
    in_instr = 32'hFE000CE3; in_tag = 5'd5;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFF8 || out_fmt !== 3'd3 || out_tag !== 5'd5) begin
      fails++;
      $display("FAIL b_format: got v=%0b imm=%h fmt=%0d tag=%0d, want 1 fffffff8 3 5",
               out_valid, out_imm, out_fmt, out_tag);
    end
    tick();
  endtask

  task automatic test_u_j();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h123450B7; in_tag = 5'd6;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_fmt !== 3'd4 || out_tag !== 5'd6) begin
      fails++;
      $display("FAIL u_format: got v=%0b imm=%h fmt=%0d tag=%0d, want 1 12345000 4 6",
               out_valid, out_imm, out_fmt, out_tag);
    end
    in_instr = 32'h0010006F; in_tag = 5'd7;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'h00000800 || out_fmt !== 3'd5 || out_tag !== 5'd7) begin
      fails++;
      $display("FAIL j_format: got v=%0b imm=%h fmt=%0d tag=%0d, want 1 00000800 5 7",
               out_valid, out_imm, out_fmt, out_tag);
    end
    // 0011011 is an RV64-only opcode, so it must decode as illegal at XLEN=32.
    in_instr = 32'h0000001B; in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_fmt !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'd0 || illegal_cnt !== 8'd1) begin
      fails++;
      $display("FAIL rv64_op_on_rv32: got fmt=%0d ill=%0b imm=%h cnt=%0d, want 7 1 0 1",
               out_fmt, out_illegal, out_imm, illegal_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 5'd10;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 5'd10) begin
      fails++;
      $display("FAIL bp_first: got rdy=%0b v=%0b tag=%0d, want 1 1 10", in_ready, out_valid, out_tag);
    end
    in_instr = 32'h00200093; in_tag = 5'd11;
    tick();
    tests++;
    if (in_ready !== 1'b0 || out_tag !== 5'd10 || out_imm !== 32'd1) begin
      fails++;
      $display("FAIL bp_full: got rdy=%0b tag=%0d imm=%h, want 0 10 1", in_ready, out_tag, out_imm);
    end
    in_instr = 32'h0000007F; in_tag = 5'd12;
    tick();
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd10 || out_imm !== 32'd1 ||
        illegal_cnt !== 8'd1) begin
      fails++;
      $display("FAIL bp_hold: got rdy=%0b v=%0b tag=%0d imm=%h cnt=%0d, want 0 1 10 1 1",
               in_ready, out_valid, out_tag, out_imm, illegal_cnt);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 5'd11 || out_imm !== 32'd2 ||
        illegal_cnt !== 8'd1) begin
      fails++;
      $display("FAIL bp_drain1: got rdy=%0b v=%0b tag=%0d imm=%h cnt=%0d, want 1 1 11 2 1",
               in_ready, out_valid, out_tag, out_imm, illegal_cnt);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_tag !== 5'd12 || out_fmt !== 3'd7 || illegal_cnt !== 8'd2) begin
      fails++;
      $display("FAIL bp_drain2: got v=%0b tag=%0d fmt=%0d cnt=%0d, want 1 12 7 2",
               out_valid, out_tag, out_fmt, illegal_cnt);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_illegal_sat();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000007F;
    for (int i = 0; i < 300; i++) begin
      in_tag = TAG_W'(i);
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_fmt !== 3'd7 || out_illegal !== 1'b1 ||
          out_imm !== 32'd0 || out_tag !== TAG_W'(i)) begin
        fails++;
        $display("FAIL illegal_word_%0d: got v=%0b rdy=%0b fmt=%0d ill=%0b imm=%h tag=%0d, want 1 1 7 1 0 %0d",
                 i, out_valid, in_ready, out_fmt, out_illegal, out_imm, out_tag, TAG_W'(i));
      end
    end
    in_instr = 32'h00000033; in_tag = 5'd1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (illegal_cnt !== 8'd255) begin
      fails++;
      $display("FAIL illegal_cnt_sat: got %0d, want 255", illegal_cnt);
    end
    tests++;
    if (out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_imm !== 32'd0 || out_tag !== 5'd1) begin
      fails++;
      $display("FAIL r_format: got fmt=%0d ill=%0b imm=%h tag=%0d, want 0 0 0 1",
               out_fmt, out_illegal, out_imm, out_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 5'd20;
    tick();
    in_instr = 32'h00500093; in_tag = 5'd21;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got v=%0b cnt=%0d rdy=%0b, want 0 0 0", out_valid, illegal_cnt, in_ready);
    end
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00700093; in_tag = 5'd22;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_tag !== 5'd22 || out_imm !== 32'd7) begin
      fails++;
      $display("FAIL post_reset_push: got v=%0b tag=%0d imm=%h, want 1 22 7", out_valid, out_tag, out_imm);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_alone: got out_valid=%0b tag=%0d, want 0", out_valid, out_tag);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_i_format();
    test_s_b();
    test_u_j();
    test_back_to_back();
    test_illegal_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
